// File: rtl/cdb_scheduler_pkg.sv
// cdb_pkg: shared constants and helpers for the CDB scheduler
package cdb_pkg;
    localparam int SB_BRANCH = 0;
    localparam int SB_TAKEN  = 1;
    localparam logic [15:0] LAT_VEC_DEFAULT = {4'd7, 4'd4, 4'd1, 4'd1};

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) ;
        return r;
    endfunction

    // unit index width, kept at least one bit for a single-unit build
    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cdb_scheduler_if.sv
// cdb_scheduler_if: unit request/result side and CDB broadcast side of the scheduler
interface cdb_scheduler_if import cdb_pkg::*; #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 6,
    parameter int SB_W      = 2
);
    localparam int IDX_W = idx_w(NUM_UNITS);
    logic [NUM_UNITS-1:0]        unit_req;
    logic [NUM_UNITS-1:0]        unit_grant;
    logic [NUM_UNITS*DATA_W-1:0] unit_result;
    logic [NUM_UNITS*TAG_W-1:0]  unit_tag;
    logic [NUM_UNITS*SB_W-1:0]   unit_sb;
    logic                        cdb_valid;
    logic [DATA_W-1:0]           cdb_data;
    logic [TAG_W-1:0]            cdb_tag;
    logic [SB_W-1:0]             cdb_sb;
    logic [IDX_W-1:0]            cdb_unit;

    modport master (
        output unit_req, unit_result, unit_tag, unit_sb,
        input  unit_grant, cdb_valid, cdb_data, cdb_tag, cdb_sb, cdb_unit
    );
    modport slave (
        input  unit_req, unit_result, unit_tag, unit_sb,
        output unit_grant, cdb_valid, cdb_data, cdb_tag, cdb_sb, cdb_unit
    );
endinterface

// File: rtl/cdb_scheduler_rr_pick.sv
// rr_pick: picks the first set request at or after ptr, wrapping around
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             multi_o
);
    // lowest request overall, overridden by the lowest one at or after ptr when present
    always_comb begin
        idx_o = '0;
        for (int j = N - 1; j >= 0; j--)
            if (req_i[j]) idx_o = IDX_W'(j);
        for (int j = N - 1; j >= 0; j--)
            if (req_i[j] && IDX_W'(j) >= ptr_i) idx_o = IDX_W'(j);
    end

    assign gnt_o   = (|req_i) ? (N'(1) << idx_o) : '0;
    assign multi_o = |(req_i & (req_i - N'(1)));
endmodule

// File: rtl/cdb_scheduler.sv
// cdb_scheduler: reserves CDB slots for fixed-latency units and broadcasts their results
module cdb_scheduler import cdb_pkg::*; #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 6,
    parameter int SB_W      = 2,
    parameter int MAX_LAT   = 8,
    parameter int LAT_W     = 4,
    parameter logic [NUM_UNITS*LAT_W-1:0] LAT_VEC = LAT_VEC_DEFAULT
) (
    input logic          clk,
    input logic          reset,
    input logic          flush,
    cdb_scheduler_if.slave bus
);
    localparam int IDX_W = idx_w(NUM_UNITS);

    function automatic int lat_of(input int i);
        return int'(LAT_VEC[i*LAT_W +: LAT_W]);
    endfunction

    // a unit leads its latency class when no lower-indexed unit shares its latency
    function automatic bit leader(input int u);
        for (int j = 0; j < u; j++)
            if (lat_of(j) == lat_of(u)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NUM_UNITS-1:0] cls_mask(input int l);
        logic [NUM_UNITS-1:0] m;
        m = '0;
        for (int j = 0; j < NUM_UNITS; j++) m[j] = (lat_of(j) == l);
        return m;
    endfunction

    logic [MAX_LAT:0]                        res_q, res_d;
    logic [MAX_LAT:0][IDX_W-1:0]             own_q, own_d;
    logic [IDX_W-1:0]                        rr_q, rr_d;
    logic [NUM_UNITS-1:0]                    elig, grant, cls_multi;
    logic [NUM_UNITS-1:0][NUM_UNITS-1:0]     cls_gnt;
    logic [NUM_UNITS-1:0][IDX_W-1:0]         cls_idx;
    int                                      best;

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
        localparam int L = lat_of(g);
        localparam logic [NUM_UNITS-1:0] CLS = cls_mask(L);
        assign elig[g] = bus.unit_req[g] & ~res_q[L] & reset & ~flush;
        if (leader(g)) begin : g_pick
            rr_pick #(.N(NUM_UNITS), .IDX_W(IDX_W)) u_pick (
                .req_i   (elig & CLS),
                .ptr_i   (rr_q),
                .gnt_o   (cls_gnt[g]),
                .idx_o   (cls_idx[g]),
                .multi_o (cls_multi[g])
            );
        end else begin : g_follow
            assign cls_gnt[g]   = '0;
            assign cls_idx[g]   = '0;
            assign cls_multi[g] = 1'b0;
        end
    end

    // merge the per-class winners into the unit grant vector
    always_comb begin
        grant = '0;
        for (int u = 0; u < NUM_UNITS; u++) grant |= cls_gnt[u];
    end

    // shift reservations toward slot 0, insert new grants, advance rr from the lowest contended class
    always_comb begin
        res_d = '0;
        own_d = '0;
        rr_d  = rr_q;
        best  = MAX_LAT + 1;
        for (int k = 0; k < MAX_LAT; k++) begin
            res_d[k] = res_q[k+1];
            own_d[k] = own_q[k+1];
            for (int i = 0; i < NUM_UNITS; i++)
                if (grant[i] && lat_of(i) == k + 1) begin
                    res_d[k] = 1'b1;
                    own_d[k] = IDX_W'(i);
                end
        end
        for (int u = 0; u < NUM_UNITS; u++)
            if (cls_multi[u] && lat_of(u) < best) begin
                best = lat_of(u);
                rr_d = (cls_idx[u] == IDX_W'(NUM_UNITS - 1)) ? '0 : cls_idx[u] + IDX_W'(1);
            end
        if (flush) res_d = '0;
    end

    // reservation, ownership and round-robin state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q <= '0;
            own_q <= '0;
            rr_q  <= '0;
        end else begin
            res_q <= res_d;
            own_q <= own_d;
            rr_q  <= rr_d;
        end
    end

    assign bus.unit_grant = grant;
    assign bus.cdb_valid  = res_q[0];
    assign bus.cdb_unit   = res_q[0] ? own_q[0] : '0;
    assign bus.cdb_data   = res_q[0] ? bus.unit_result[own_q[0]*DATA_W +: DATA_W] : '0;
    assign bus.cdb_tag    = res_q[0] ? bus.unit_tag[own_q[0]*TAG_W +: TAG_W] : '0;
    assign bus.cdb_sb     = res_q[0] ? bus.unit_sb[own_q[0]*SB_W +: SB_W] : '0;
endmodule

// File: tb/tb_cdb_scheduler.sv
// tb_cdb_scheduler: directed vector table plus hand sequences for the CDB scheduler
module tb_cdb_scheduler;
    import cdb_pkg::*;

    typedef struct {
        logic       rst;
        logic       fl;
        logic [3:0] req;
        logic [3:0] g;
        logic       v;
        logic [1:0] u;
    } vec_t;

    logic clk = 1'b0;
    logic reset, flush;
    int checks = 0, errors = 0;
    vec_t vecs[$];

    logic [31:0] res_c [4] = '{32'hDEAD_BEEF, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    logic [5:0]  tag_c [4] = '{6'h05, 6'h11, 6'h22, 6'h33};
    logic [1:0]  sb_c  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    always #5 clk = ~clk;

    cdb_scheduler_if #(.NUM_UNITS(4), .DATA_W(32), .TAG_W(6), .SB_W(2)) bus ();

    cdb_scheduler #(
        .NUM_UNITS(4), .DATA_W(32), .TAG_W(6), .SB_W(2),
        .MAX_LAT(8), .LAT_W(4), .LAT_VEC(16'h7411)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] g, input logic v, input logic [1:0] u);
        chk({nm, " grant"}, 32'(bus.unit_grant), 32'(g));
        chk({nm, " valid"}, 32'(bus.cdb_valid), 32'(v));
        chk({nm, " unit"},  32'(bus.cdb_unit), v ? 32'(u) : 32'd0);
        chk({nm, " data"},  bus.cdb_data, v ? res_c[u] : 32'd0);
        chk({nm, " tag"},   32'(bus.cdb_tag), v ? 32'(tag_c[u]) : 32'd0);
        chk({nm, " sb"},    32'(bus.cdb_sb), v ? 32'(sb_c[u]) : 32'd0);
    endtask

    function automatic void add(input logic r, input logic f, input logic [3:0] q,
                                input logic [3:0] g, input logic v, input logic [1:0] u);
        vecs.push_back('{r, f, q, g, v, u});
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) add(1, 0, 4'b0000, 4'b0000, 0, 0);
    endfunction

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        bus.unit_req    = '0;
        bus.unit_result = {res_c[3], res_c[2], res_c[1], res_c[0]};
        bus.unit_tag    = {tag_c[3], tag_c[2], tag_c[1], tag_c[0]};
        bus.unit_sb     = {sb_c[3], sb_c[2], sb_c[1], sb_c[0]};

        // reset held with every unit requesting, then release with three latency classes at once
        for (int i = 0; i < 3; i++) add(0, 0, 4'b1111, 4'b0000, 0, 0);
        add(1, 0, 4'b1101, 4'b1101, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 1, 0);
        add_idle(2);
        add(1, 0, 4'b0000, 4'b0000, 1, 2);
        add_idle(2);
        add(1, 0, 4'b0000, 4'b0000, 1, 3);
        // single u0 issue, one-cycle latency
        add(1, 0, 4'b0001, 4'b0001, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 1, 0);
        // u0/u1 contention alternates
        add(1, 0, 4'b0011, 4'b0001, 0, 0);
        add(1, 0, 4'b0011, 4'b0010, 1, 0);
        add(1, 0, 4'b0011, 4'b0001, 1, 1);
        add(1, 0, 4'b0011, 4'b0010, 1, 0);
        add(1, 0, 4'b0000, 4'b0000, 1, 1);
        // u2 blocked by u3's slot, issues one cycle later
        add(1, 0, 4'b1000, 4'b1000, 0, 0);
        add_idle(2);
        add(1, 0, 4'b0100, 4'b0000, 0, 0);
        add(1, 0, 4'b0100, 4'b0100, 0, 0);
        add_idle(2);
        add(1, 0, 4'b0000, 4'b0000, 1, 3);
        add(1, 0, 4'b0000, 4'b0000, 1, 2);
        // u0 blocked by u3's slot
        add(1, 0, 4'b1000, 4'b1000, 0, 0);
        add_idle(5);
        add(1, 0, 4'b0001, 4'b0000, 0, 0);
        add(1, 0, 4'b0001, 4'b0001, 1, 3);
        add(1, 0, 4'b0000, 4'b0000, 1, 0);
        // flush cancels u3 in flight and blocks grants
        add(1, 0, 4'b1000, 4'b1000, 0, 0);
        add_idle(1);
        add(1, 1, 4'b1111, 4'b0000, 0, 0);
        add_idle(6);
        // flush lets the slot-0 broadcast finish; rr untouched (pointer 2 wraps to u0)
        add(1, 0, 4'b0001, 4'b0001, 0, 0);
        add(1, 1, 4'b0011, 4'b0000, 1, 0);
        add_idle(1);
        add(1, 0, 4'b0011, 4'b0001, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 1, 0);

        foreach (vecs[i]) begin
            reset        = vecs[i].rst;
            flush        = vecs[i].fl;
            bus.unit_req = vecs[i].req;
            @(negedge clk);
            chk_out($sformatf("row%0d", i), vecs[i].g, vecs[i].v, vecs[i].u);
            @(posedge clk);
            #1;
        end

        // u3 issued, then an asynchronous reset pulse mid-cycle at t+3 drops it
        bus.unit_req = 4'b1000;
        @(negedge clk);
        chk_out("rst t", 4'b1000, 0, 0);
        @(posedge clk);
        #1;
        bus.unit_req = 4'b0000;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk_out($sformatf("rst t+%0d", i), 4'b0000, 0, 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        bus.unit_req = 4'b1111;
        #1;
        chk_out("rst pulse", 4'b0000, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.unit_req = 4'b0000;
        @(posedge clk);
        #1;
        for (int i = 4; i <= 8; i++) begin
            @(negedge clk);
            chk_out($sformatf("rst t+%0d", i), 4'b0000, 0, 0);
            @(posedge clk);
            #1;
        end
        // pointer was 1 before the pulse; reset returns it to 0 so u0 wins
        bus.unit_req = 4'b0011;
        @(negedge clk);
        chk_out("rr after rst", 4'b0001, 0, 0);
        @(posedge clk);
        #1;
        bus.unit_req = 4'b0000;
        @(negedge clk);
        chk_out("rr after rst bcast", 4'b0000, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
